// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, state type and pattern-index step helper
package led_pkg;

    localparam int LED_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Next (up=1) or previous (up=0) pattern index, wrapping within 0..num-1.
    function automatic int unsigned sel_step(input int unsigned sel, input logic up,
                                             input int unsigned num);
        if (up) begin
            return (sel == num - 1) ? 0 : sel + 1;
        end
        return (sel == 0) ? num - 1 : sel - 1;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - board controls and pattern-engine bus of the sequencer
interface led_pattern_sequencer_if #(
    parameter int NUM_PAT = 4,
    parameter int SEL_W   = 3
);
    import led_pkg::*;

    logic                     en;
    logic                     next_btn;
    logic                     auto_mode;
    logic                     dir;
    logic [LED_W*NUM_PAT-1:0] pat_in;
    logic [NUM_PAT-1:0]       pat_en;
    logic [NUM_PAT-1:0]       pat_rst;
    logic [SEL_W-1:0]         pat_sel;
    logic [LED_W-1:0]         leds;

    modport master (
        input  en, next_btn, auto_mode, dir, pat_in,
        output pat_en, pat_rst, pat_sel, leds
    );

    modport slave (
        output en, next_btn, auto_mode, dir, pat_in,
        input  pat_en, pat_rst, pat_sel, leds
    );

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running power-of-two tick divider with clear and enable
module tick_divider #(
    parameter int DIV_BITS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_BITS-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en & (&div_q);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - selects, restarts and enables one LED pattern engine at a time
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int DIV_BITS = 20,
    parameter int DWELL    = 16,
    parameter int NUM_PAT  = 4,
    parameter int SEL_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    led_pattern_sequencer_if.master bus
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic             btn_q;
    logic             btn_edge;
    logic             run;
    logic             tick;
    logic             advance;

    assign run      = (state_q == ST_RUN);
    assign btn_edge = bus.next_btn & ~btn_q;
    assign advance  = btn_edge | (bus.auto_mode & tick & (dwell_q == DW_W'(DWELL - 1)));

    tick_divider #(.DIV_BITS(DIV_BITS)) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (~run),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        leds_d  = '0;
        case (state_q)
            ST_IDLE: begin
                dwell_d = '0;
                if (bus.en) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                dwell_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.auto_mode) begin
                    dwell_d = '0;
                end else if (tick) begin
                    dwell_d = dwell_q + 1'b1;
                end
                // en low wins over any advance and keeps the current selection
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (advance) begin
                    state_d = ST_SWITCH;
                    sel_d   = SEL_W'(sel_step(32'(sel_q), bus.dir, NUM_PAT));
                end else begin
                    leds_d = LED_W'(bus.pat_in >> (LED_W * int'(sel_q)));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.pat_en  = '0;
        bus.pat_rst = '0;
        case (state_q)
            ST_SWITCH: bus.pat_rst = NUM_PAT'(1) << sel_q;
            ST_RUN:    bus.pat_en  = NUM_PAT'(1) << sel_q;
            default:   bus.pat_rst = '1;
        endcase
    end

    assign bus.pat_sel = sel_q;
    assign bus.leds    = leds_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dwell_q <= '0;
            leds_q  <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            leds_q  <= leds_d;
            btn_q   <= bus.next_btn;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

    localparam int NP       = 4;
    localparam int DWELL    = 3;
    localparam int DIV_BITS = 2;
    localparam int PERIOD   = 1 << DIV_BITS;
    localparam int K_SW     = 0;
    localparam int K_IDLE   = 1;

    typedef struct {
        int kind;
        int cyc;
        int sel;
    } ev_t;

    ev_t  exp_q[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: pattern on/restarting, selection, run length and dwell ticks
    bit   m_on = 0;
    bit   m_fresh = 0;
    bit   m_btn_prev = 0;
    int   m_sel = 0;
    int   m_run = 0;
    int   m_ticks = 0;

    // monitor state
    bit   mon_prev_ones = 1;
    int   mon_run = 0;
    int   mon_sel = 0;
    int   mon_sw = -10;

    led_pattern_sequencer_if #(.NUM_PAT(NP), .SEL_W(3)) bus ();

    led_pattern_sequencer #(
        .DIV_BITS (DIV_BITS),
        .DWELL    (DWELL),
        .NUM_PAT  (NP),
        .SEL_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pack(input int s, input int e, input int r, input int l);
        return (s << 18) | (e << 14) | (r << 10) | l;
    endfunction

    function automatic int dut_out();
        return pack(int'(bus.pat_sel), int'(bus.pat_en), int'(bus.pat_rst), int'(bus.leds));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int c, input int s);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.sel  = s;
        exp_q.push_back(e);
    endtask

    function automatic bit m_tick();
        return (m_run % PERIOD) == PERIOD - 1;
    endfunction

    // Decides what the next cycle looks like from this cycle's inputs.
    task automatic model_step();
        bit edge_now, expire;
        edge_now   = bus.next_btn && !m_btn_prev;
        m_btn_prev = bus.next_btn;
        if (!m_on) begin
            if (bus.en) begin
                m_on = 1; m_fresh = 1;
                push_ev(K_SW, cyc + 1, m_sel);
            end
        end else if (m_fresh) begin
            m_fresh = 0; m_run = 0; m_ticks = 0;
        end else begin
            expire = bus.auto_mode && m_tick() && (m_ticks == DWELL - 1);
            if (!bus.en) begin
                m_on = 0;
                push_ev(K_IDLE, cyc + 1, m_sel);
            end else if (edge_now || expire) begin
                m_sel   = bus.dir ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
                m_fresh = 1;
                push_ev(K_SW, cyc + 1, m_sel);
            end else begin
                if (!bus.auto_mode) m_ticks = 0;
                else if (m_tick()) m_ticks++;
                m_run++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_on = 0; m_fresh = 0; m_sel = 0; m_btn_prev = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        bit ones, sw;
        ev_t e;
        forever begin
            @(negedge clk);
            ones = (bus.pat_rst == 4'hF);
            sw   = $onehot(bus.pat_rst);
            if (sw || (ones && !mon_prev_ones)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", sw ? K_SW : K_IDLE, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", sw ? K_SW : K_IDLE, e.kind);
                    chk("event_cycle", cyc, e.cyc);
                    mon_sel = e.sel;
                    if (e.kind == K_SW) begin
                        mon_run = 1;
                        mon_sw  = cyc;
                        chk("switch_out", dut_out(), pack(e.sel, 0, 1 << e.sel, 0));
                    end else begin
                        mon_run = 0;
                        chk("idle_entry_out", dut_out(), pack(e.sel, 0, 15, 0));
                    end
                end
            end else if (mon_run == 1) begin
                chk("run_out", dut_out(),
                    pack(mon_sel, 1 << mon_sel, 0, (cyc == mon_sw + 1) ? 0 : (1 << mon_sel)));
            end else begin
                chk("idle_out", dut_out(), pack(mon_sel, 0, 15, 0));
            end
            mon_prev_ones = ones;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; asserts rst between edges while a pattern is running.
    task automatic async_reset_mid(output bit taken);
        taken = 0;
        #1;
        if (m_on && !m_fresh && exp_q.size() == 0) begin
            taken = 1;
            push_ev(K_IDLE, cyc, 0);
            m_on = 0; m_fresh = 0; m_sel = 0; m_btn_prev = 0;
            rst = 1'b1;
            #1;
            chk("async_rst_out", dut_out(), pack(0, 0, 15, 0));
            @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit expiry_now();
        return m_on && !m_fresh && bus.en && bus.auto_mode && m_tick()
               && (m_ticks == DWELL - 1) && !bus.next_btn && !m_btn_prev;
    endfunction

    initial begin
        bit done, taken;
        bus.en        = 1'b0;
        bus.next_btn  = 1'b0;
        bus.auto_mode = 1'b0;
        bus.dir       = 1'b1;
        for (int k = 0; k < NP; k++) bus.pat_in[10*k +: 10] = 10'h001 << k;

        step(3);
        rst = 1'b0;
        chk("reset_out", dut_out(), pack(0, 0, 15, 0));
        step(3);
        bus.en = 1'b1;
        step(8);

        bus.dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.next_btn = 1'b1;
            step(10);
            bus.next_btn = 1'b0;
            step(2);
        end

        bus.dir = 1'b0;
        bus.next_btn = 1'b1;
        step(1);
        bus.next_btn = 1'b0;
        step(6);

        bus.dir = 1'b1;
        bus.auto_mode = 1'b1;
        step(30);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (expiry_now()) begin
                bus.next_btn = 1'b1;
                done = 1;
            end
            step(1);
        end
        chk("expiry_press_found", int'(done), 1);
        bus.next_btn = 1'b0;
        step(16);

        bus.en = 1'b0;
        step(4);
        bus.en = 1'b1;
        step(13);

        async_reset_mid(taken);
        chk("async_rst_taken", int'(taken), 1);
        step(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3)  bus.en = ~bus.en;
            if ($urandom_range(99) < 12) bus.next_btn = ~bus.next_btn;
            if ($urandom_range(99) < 4)  bus.auto_mode = ~bus.auto_mode;
            bus.dir = 1'($urandom_range(1));
            if ($urandom_range(999) < 4) async_reset_mid(taken);
            else step(1);
        end

        bus.en = 1'b1;
        bus.next_btn = 1'b0;
        bus.auto_mode = 1'b0;
        step(6);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller for the DE10 LED pattern engines (counter, rotate, etc.). Each engine drives a 10-bit LEDR pattern and has a synchronous reset and an enable.
- Owns every engine's enable and reset, and selects exactly one engine to drive LEDR[9:0].
- Advances to the next pattern on a button press, or automatically after a dwell time; `dir` sets the advance direction.
- Sits between the board I/O (KEY/SW, already synchronized) and the pattern engine instances.

Parameters:
- DIV_BITS, 20, width of the internal tick divider; one tick every 2^DIV_BITS enabled clocks.
- DWELL, 16, ticks spent on each pattern in auto mode; legal range >= 1.
- NUM_PAT, 4, number of pattern engines; legal range 2..8.
- SEL_W, 3, width of `pat_sel`; must satisfy 2^SEL_W >= NUM_PAT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable (switch level).
- next_btn  in  1  advance request; level input, already synchronized and debounced, active-high; rising edge detected internally.
- auto_mode  in  1  1 = auto-advance after DWELL ticks.
- dir  in  1  1 = advance upward (sel+1), 0 = advance downward (sel-1).
- pat_in  in  10*NUM_PAT  concatenated engine outputs; engine k occupies bits [10k+9:10k].
- pat_en  out  NUM_PAT  one-hot enable to the engines.
- pat_rst  out  NUM_PAT  synchronous reset to the engines.
- pat_sel  out  SEL_W  index of the active pattern.
- leds  out  10  LED drive.

Behaviour:
- Reset (async) values: state=IDLE, pat_sel=0, leds=0, pat_en=0, pat_rst=all ones, divider=0, dwell_cnt=0, btn_q=0.
- Edge detect: btn_q <= next_btn every clock; btn_edge = next_btn & ~btn_q.
- Divider: counts only while state=RUN; tick = &div. Divider is cleared in IDLE and SWITCH.
- States:
  - IDLE: pat_en=0, pat_rst=all ones, leds=0. When en=1, go to SWITCH without changing pat_sel. This gives a clean restart of the current pattern.
  - SWITCH: lasts exactly 1 cycle. pat_rst is one-hot at pat_sel (others 0), pat_en=0, leds=0, dwell_cnt=0. Always goes to RUN next.
  - RUN: pat_en is one-hot at pat_sel; pat_rst=0; leds <= pat_in[10*pat_sel +: 10] (registered, 1-cycle latency).
    - If en=0, go to IDLE (checked first; has priority).
    - Otherwise, an advance request goes to SWITCH and updates pat_sel in the same clock. An advance request is btn_edge, OR auto_mode & tick & (dwell_cnt==DWELL-1).
- pat_sel update:
  - dir=1: pat_sel = (pat_sel==NUM_PAT-1) ? 0 : pat_sel+1.
  - dir=0: pat_sel = (pat_sel==0) ? NUM_PAT-1 : pat_sel-1.
- dwell_cnt:
  - Increments on tick in RUN when auto_mode=1.
  - Held at 0 when auto_mode=0.
  - Cleared on every SWITCH.
- Boundary conditions:
  - btn_edge and dwell expiry in the same cycle: a single advance by one step.
  - btn_edge while in SWITCH or IDLE: ignored (not queued).
  - en falling in the same cycle as an advance request: go to IDLE and leave pat_sel unchanged.
  - auto_mode dropping mid-dwell: dwell_cnt clears, pattern holds.
  - dir is sampled only at the advance cycle.
  - rst asserted mid-operation: all outputs return to their reset values immediately.
- Invariant: at most one bit of pat_en is set. pat_en and pat_rst never have the same bit set.

Decomposition:
- Shared package `led_pkg` holds:
  - LED_W=10.
  - State encoding (IDLE, SWITCH, RUN as localparams).
  - A NEXT/PREV sel helper function with wrap-around.
- One sub-module, `tick_divider`, with ports clk, rst, en, clr, tick and parameter DIV_BITS. The pattern engines can reuse it later.

Test Plan:
Bench parameters for all scenarios: DIV_BITS=2, DWELL=3, NUM_PAT=4. Engine k is modelled as constant pat_in slice 10'h001<<k.
1. Reset/start: rst pulse, then en=1 → cycle 1 SWITCH with pat_rst=4'b0001, leds=0; cycle 2 RUN with pat_en=4'b0001; cycle 3 leds=10'h001.
2. Button walk up: dir=1, four rising edges of next_btn spaced 10 cycles apart → pat_sel 1,2,3,0. Each edge gives exactly one SWITCH cycle; leds follow 10'h002, 10'h004, 10'h008, 10'h001. Holding the button high gives no repeat advance.
3. Wrap down: pat_sel=0, dir=0, one press → pat_sel=3, pat_rst=4'b1000 for 1 cycle, then leds=10'h008.
4. Auto dwell: auto_mode=1, no presses → an advance every 3 ticks (12 RUN cycles + 1 SWITCH cycle). A press on the exact expiry cycle advances by only 1.
5. en drop: en=0 mid-RUN → next cycle IDLE, pat_en=0, pat_rst=4'b1111, leds=0, pat_sel retained. en=1 then restarts the same pattern through SWITCH.
6. Async reset mid-dwell: rst asserted between clock edges → outputs reset without waiting for a clock edge; pat_sel=0, dwell_cnt=0, divider=0.
